adc_capture_buf: RTL and testbench

// Parametrised multichannel sample-capture sequencer that sits between the ADC sampler and the sample RAM.

---
 rtl/adc_capture_buf_if.sv | 36 +++
 rtl/adc_capture_buf.sv | 177 +++++++++++++++++
 tb/tb_adc_capture_buf.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_buf_if.sv
// adc_capture_buf bus: sampler/control inputs and RAM write port.
// master drives capture control, slave is the capture sequencer.
interface adc_capture_buf_if #(
  parameter int NUM_CH = 4,
  parameter int DW     = 8,
  parameter int DEPTH  = 512
);
  localparam int AW = $clog2(DEPTH * NUM_CH);

  logic                 start;
  logic                 stop;
  logic                 mode;
  logic                 sample_valid;
  logic [NUM_CH*DW-1:0] sample_data;
  logic [AW-1:0]        w_addr;
  logic [DW-1:0]        w_data;
  logic                 wren;
  logic                 busy;
  logic                 done;
  logic                 frame_done;
  logic                 overrun;

  modport master (
    output start, stop, mode,
    output sample_valid, sample_data,
    input  w_addr, w_data, wren,
    input  busy, done, frame_done, overrun
  );

  modport slave (
    input  start, stop, mode,
    input  sample_valid, sample_data,
    output w_addr, w_data, wren,
    output busy, done, frame_done, overrun
  );
endinterface

// File: rtl/adc_capture_buf.sv
// Multichannel sample-capture sequencer: decimates samples and
// serialises each kept sample into NUM_CH RAM writes.
module adc_capture_buf #(
  parameter int NUM_CH = 4,
  parameter int DW     = 8,
  parameter int DEPTH  = 512,
  parameter int DECIM  = 1
) (
  input logic            clk,
  input logic            n_rst,
  adc_capture_buf_if.slave bus
);
  localparam int CB  = $clog2(NUM_CH);
  localparam int CW  = (CB > 0) ? CB : 1;
  localparam int SW  = $clog2(DEPTH);
  localparam int AW  = SW + CB;
  localparam int DB  = $clog2(DECIM);
  localparam int DCW = (DB > 0) ? DB : 1;
  localparam int XW  = NUM_CH * DW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  sidx_q, sidx_d;
  logic [CW-1:0]  ch_q, ch_d;
  logic [DCW-1:0] dec_q, dec_d;
  logic           stop_req_q, stop_req_d;
  logic           mode_q, mode_d;
  logic [XW-1:0]  shadow_q, shadow_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  data_q, data_d;
  logic           wren_q, wren_d;
  logic           fdone_q, fdone_d;
  logic           ovr_q, ovr_d;

  logic [CW-1:0]  ch_n;
  logic [DCW-1:0] dec_inc;
  logic           keep;
  logic           last_ch;
  logic           ending;
  logic           take;
  logic [SW-1:0]  take_idx;

  function automatic logic [AW-1:0] mk_addr(
    input logic [SW-1:0] s,
    input logic [CW-1:0] c
  );
    mk_addr = (AW'(s) << CB) | AW'(c);
  endfunction

  assign ch_n    = ch_q + CW'(1);
  assign keep    = (dec_q == '0);
  assign dec_inc = (dec_q == DCW'(DECIM - 1)) ?
                   '0 : dec_q + DCW'(1);
  assign last_ch = (ch_q == CW'(NUM_CH - 1));
  // capture ends after this sample's last write
  assign ending  = bus.stop | stop_req_q |
                   (!mode_q && sidx_q == SW'(DEPTH - 1));

  // next-state and write-port logic
  always_comb begin
    state_d    = state_q;
    sidx_d     = sidx_q;
    ch_d       = ch_q;
    dec_d      = dec_q;
    stop_req_d = stop_req_q;
    mode_d     = mode_q;
    shadow_d   = shadow_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wren_d     = 1'b0;
    fdone_d    = 1'b0;
    ovr_d      = ovr_q;
    take       = 1'b0;
    take_idx   = sidx_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          sidx_d     = '0;
          ch_d       = '0;
          dec_d      = '0;
          ovr_d      = 1'b0;
          stop_req_d = 1'b0;
          mode_d     = bus.mode;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.stop) begin
          state_d = S_DONE;
        end else if (bus.sample_valid) begin
          dec_d = dec_inc;
          take  = keep;
        end
      end
      S_WRITE: begin
        if (!last_ch) begin
          if (bus.stop) stop_req_d = 1'b1;
          if (bus.sample_valid) ovr_d = 1'b1;
          ch_d   = ch_n;
          wren_d = 1'b1;
          addr_d = mk_addr(sidx_q, ch_n);
          data_d = shadow_q[ch_n*DW +: DW];
        end else begin
          sidx_d   = sidx_q + SW'(1);
          take_idx = sidx_q + SW'(1);
          ch_d     = '0;
          if (ending) begin
            stop_req_d = 1'b0;
            state_d    = S_DONE;
          end else begin
            state_d = S_WAIT;
            if (bus.sample_valid) begin
              dec_d = dec_inc;
              take  = keep;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (take) begin
      state_d  = S_WRITE;
      shadow_d = bus.sample_data;
      ch_d     = '0;
      wren_d   = 1'b1;
      addr_d   = mk_addr(take_idx, '0);
      data_d   = bus.sample_data[DW-1:0];
    end
    fdone_d = wren_d && (addr_d == '1);
  end

  // state and registered write port
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      sidx_q     <= '0;
      ch_q       <= '0;
      dec_q      <= '0;
      stop_req_q <= 1'b0;
      mode_q     <= 1'b0;
      shadow_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wren_q     <= 1'b0;
      fdone_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sidx_q     <= sidx_d;
      ch_q       <= ch_d;
      dec_q      <= dec_d;
      stop_req_q <= stop_req_d;
      mode_q     <= mode_d;
      shadow_q   <= shadow_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wren_q     <= wren_d;
      fdone_q    <= fdone_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.w_addr     = addr_q;
  assign bus.w_data     = data_q;
  assign bus.wren       = wren_q;
  assign bus.frame_done = fdone_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state_q == S_WAIT) |
                          (state_q == S_WRITE);
  assign bus.done       = (state_q == S_DONE);
endmodule

// File: tb/tb_adc_capture_buf.sv
// Randomised bench for adc_capture_buf: two instances (DECIM 1 and 3)
// share stimulus and are checked against a write-list model.
module tb_adc_capture_buf;
  localparam int NC   = 4;
  localparam int DW   = 8;
  localparam int DEP  = 8;
  localparam int MAXN = 160;
  localparam int AMAX = DEP * NC - 1;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic mode = 1'b0;
  logic sv = 1'b0;
  logic [NC*DW-1:0] sd = '0;

  always #5 clk = ~clk;

  adc_capture_buf_if #(.NUM_CH(NC), .DW(DW), .DEPTH(DEP)) b0 ();
  adc_capture_buf_if #(.NUM_CH(NC), .DW(DW), .DEPTH(DEP)) b1 ();

  assign b0.start        = start;
  assign b0.stop         = stop;
  assign b0.mode         = mode;
  assign b0.sample_valid = sv;
  assign b0.sample_data  = sd;
  assign b1.start        = start;
  assign b1.stop         = stop;
  assign b1.mode         = mode;
  assign b1.sample_valid = sv;
  assign b1.sample_data  = sd;

  adc_capture_buf #(
    .NUM_CH(NC), .DW(DW), .DEPTH(DEP), .DECIM(1)
  ) u0 (
    .clk(clk), .n_rst(n_rst), .bus(b0)
  );

  adc_capture_buf #(
    .NUM_CH(NC), .DW(DW), .DEPTH(DEP), .DECIM(3)
  ) u1 (
    .clk(clk), .n_rst(n_rst), .bus(b1)
  );

  int n_chk = 0;
  int n_err = 0;

  bit          vld[MAXN];
  bit          stp[MAXN];
  logic [31:0] dat[MAXN];
  int          N;
  bit          tmode;
  logic [63:0] eq[$];
  logic [63:0] e0[$];
  logic [63:0] e1[$];
  logic [63:0] a0[$];
  logic [63:0] a1[$];
  int          gaps[8] = '{1, 2, 3, 4, 4, 5, 6, 8};

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int cyc, input bit fd,
                                     input int a, input int d);
    return {16'(cyc), 8'(fd), 16'(a), 24'(d)};
  endfunction

  task automatic clr();
    for (int i = 0; i < MAXN; i++) begin
      vld[i] = 1'b0;
      stp[i] = 1'b0;
      dat[i] = '0;
    end
  endtask

  // Expected writes: a kept sample at cycle t is written on cycles
  // t+1..t+NC; samples arriving while a sample is still being
  // written are dropped and flag overrun.
  task automatic model(input int decim, output bit ovr,
                       output bit bsy);
    int free;
    int e;
    int cnt;
    int n;
    int a;
    free = 1;
    e    = 1 << 30;
    cnt  = 0;
    n    = 0;
    ovr  = 1'b0;
    bsy  = 1'b0;
    eq.delete();
    for (int k = 1; k <= N; k++) begin
      if (k == N) bsy = !(e <= N - 1);
      if (stp[k] && k < e) e = (k < free) ? free : k;
      if (k < N && vld[k]) begin
        if (k < free) begin
          ovr = 1'b1;
        end else if (k < e) begin
          if (cnt % decim == 0) begin
            for (int c = 0; c < NC; c++) begin
              a = (n % DEP) * NC + c;
              eq.push_back(pk(k + 1 + c, a == AMAX, a,
                              int'((dat[k] >> (8 * c)) & 32'hff)));
            end
            n++;
            free = k + NC;
            if (!tmode && n == DEP) e = free;
          end
          cnt++;
        end
      end
    end
  endtask

  task automatic cmp_q(input string nm,
                       input logic [63:0] ex[$],
                       input logic [63:0] ac[$]);
    int m;
    chk({nm, " nwr"}, 64'(ac.size()), 64'(ex.size()));
    m = (ac.size() < ex.size()) ? ac.size() : ex.size();
    for (int i = 0; i < m; i++) chk({nm, " wr"}, ac[i], ex[i]);
  endtask

  task automatic run_trial(input string nm);
    bit o0;
    bit o1;
    bit x0;
    bit x1;
    int last;
    last = N + NC + 4;
    model(1, o0, x0);
    e0 = eq;
    model(3, o1, x1);
    e1 = eq;
    a0.delete();
    a1.delete();
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (b0.wren)
          a0.push_back(pk(k, b0.frame_done,
                          int'(b0.w_addr), int'(b0.w_data)));
        if (b1.wren)
          a1.push_back(pk(k, b1.frame_done,
                          int'(b1.w_addr), int'(b1.w_data)));
        if (b0.frame_done && !b0.wren)
          chk({nm, " fd0_nowr"}, 64'(1), 64'(0));
        if (b1.frame_done && !b1.wren)
          chk({nm, " fd1_nowr"}, 64'(1), 64'(0));
      end
      if (k == N) begin
        chk({nm, " busy0"}, 64'(b0.busy), 64'(x0));
        chk({nm, " busy1"}, 64'(b1.busy), 64'(x1));
      end
      start = (k == 0);
      mode  = tmode;
      sv    = (k < N) && vld[k];
      sd    = dat[k];
      stop  = stp[k];
    end
    start = 1'b0;
    stop  = 1'b0;
    sv    = 1'b0;
    cmp_q({nm, " d0"}, e0, a0);
    cmp_q({nm, " d1"}, e1, a1);
    chk({nm, " ovr0"}, 64'(b0.overrun), 64'(o0));
    chk({nm, " ovr1"}, 64'(b1.overrun), 64'(o1));
    chk({nm, " done0"}, 64'(b0.done), 64'(1));
    chk({nm, " done1"}, 64'(b1.done), 64'(1));
    chk({nm, " idle0"}, 64'(b0.busy), 64'(0));
    chk({nm, " idle1"}, 64'(b1.busy), 64'(0));
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst wren", 64'(b0.wren), 64'(0));
    chk("rst busy", 64'(b0.busy), 64'(0));
    chk("rst done", 64'(b0.done), 64'(0));
    chk("rst fdone", 64'(b0.frame_done), 64'(0));
    chk("rst ovr", 64'(b0.overrun), 64'(0));
    chk("rst addr", 64'(b0.w_addr), 64'(0));
    chk("rst data", 64'(b0.w_data), 64'(0));
    chk("rst busy1", 64'(b1.busy), 64'(0));
    n_rst = 1'b1;

    clr();
    tmode = 1'b0;
    N = 60;
    for (int j = 0; j < 8; j++) begin
      t = 1 + 6 * j;
      vld[t] = 1'b1;
      dat[t] = {8'(j + 3), 8'(j + 2), 8'(j + 1), 8'(j)};
    end
    stp[N] = 1'b1;
    run_trial("single");

    clr();
    tmode = 1'b0;
    N = 40;
    for (int j = 0; j < 9; j++) begin
      vld[1 + 4 * j] = 1'b1;
      dat[1 + 4 * j] = $urandom;
    end
    stp[N] = 1'b1;
    run_trial("b2b");

    clr();
    tmode = 1'b0;
    N = 40;
    for (int j = 0; j < 19; j++) begin
      vld[1 + 2 * j] = 1'b1;
      dat[1 + 2 * j] = $urandom;
    end
    stp[N] = 1'b1;
    run_trial("ovrun");

    clr();
    tmode = 1'b1;
    N = 90;
    for (int j = 0; j < 21; j++) begin
      vld[1 + 4 * j] = 1'b1;
      dat[1 + 4 * j] = $urandom;
    end
    stp[83] = 1'b1;
    stp[N] = 1'b1;
    run_trial("cont");

    for (int r = 0; r < 20; r++) begin
      clr();
      tmode = 1'($urandom % 2);
      N = 20 + int'($urandom % 60);
      t = 1 + int'($urandom % 3);
      while (t < N) begin
        vld[t] = 1'b1;
        dat[t] = $urandom;
        t += gaps[$urandom % 8];
      end
      if ($urandom % 3 == 0) stp[1 + int'($urandom % (N - 1))] = 1'b1;
      stp[N] = 1'b1;
      run_trial("rnd");
    end

    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    sv    = 1'b1;
    sd    = 32'hA4A3A2A1;
    @(negedge clk);
    sv    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("prerst wren", 64'(b0.wren), 64'(1));
    chk("prerst addr", 64'(b0.w_addr), 64'(2));
    chk("prerst data", 64'(b1.w_data), 64'(8'hA3));
    n_rst = 1'b0;
    #1;
    chk("arst wren0", 64'(b0.wren), 64'(0));
    chk("arst busy0", 64'(b0.busy), 64'(0));
    chk("arst done0", 64'(b0.done), 64'(0));
    chk("arst wren1", 64'(b1.wren), 64'(0));
    chk("arst busy1", 64'(b1.busy), 64'(0));
    @(negedge clk);
    n_rst = 1'b1;

    clr();
    tmode = 1'b0;
    N = 12;
    vld[3] = 1'b1;
    dat[3] = $urandom;
    stp[N] = 1'b1;
    run_trial("postrst");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
